// File: rtl/atm_pkg.sv
// ---------------------------------------------------------------------------
// atm_pkg
//   Shared definitions for the ATM session controller:
//     - state_t   : session FSM state encoding
//     - OP_*      : bank_op / menu_option codes (FIND, AUTHENTICATE, BALANCE..DEPOSIT)
//     - ERR_*     : err_code values reported with op_error / op_done
//     - helpers   : classification of menu selections
// ---------------------------------------------------------------------------
package atm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FIND      = 3'd1,
    ST_ENTER_PIN = 3'd2,
    ST_AUTH      = 3'd3,
    ST_MENU      = 3'd4,
    ST_EXEC      = 3'd5
  } state_t;

  // Bank operation codes; menu selections 3..7 are forwarded unchanged.
  localparam logic [2:0] OP_FIND               = 3'd0;
  localparam logic [2:0] OP_AUTHENTICATE       = 3'd1;
  localparam logic [2:0] OP_BALANCE            = 3'd3;
  localparam logic [2:0] OP_WITHDRAW           = 3'd4;
  localparam logic [2:0] OP_WITHDRAW_SHOW_BAL  = 3'd5;
  localparam logic [2:0] OP_TRANSACTION        = 3'd6;
  localparam logic [2:0] OP_DEPOSIT            = 3'd7;

  localparam logic [2:0] ERR_NONE              = 3'd0;
  localparam logic [2:0] ERR_NOT_FOUND         = 3'd1;
  localparam logic [2:0] ERR_BAD_PIN           = 3'd2;
  localparam logic [2:0] ERR_LOCKED            = 3'd3;
  localparam logic [2:0] ERR_INSUFFICIENT      = 3'd4;
  localparam logic [2:0] ERR_BAD_REQUEST       = 3'd5;
  localparam logic [2:0] ERR_BANK_TIMEOUT      = 3'd6;
  localparam logic [2:0] ERR_SESSION_TIMEOUT   = 3'd7;

  // Menu codes below BALANCE are not customer operations.
  function automatic logic menu_is_bank_op(input logic [2:0] opt);
    return (opt >= OP_BALANCE);
  endfunction

  // Every money-moving operation needs a non-zero amount.
  function automatic logic menu_needs_amount(input logic [2:0] opt);
    return (opt >= OP_WITHDRAW);
  endfunction

endpackage

// File: rtl/atm_session_ctrl_if.sv
// ---------------------------------------------------------------------------
// atm_session_ctrl_if
//   Request/acknowledge bus between the session controller (master) and the
//   account-store core (slave). One operation is outstanding at a time.
//     bank_req     master->slave  request held until ack is sampled
//     bank_op      master->slave  operation code (atm_pkg::OP_*)
//     bank_acc     master->slave  account number
//     bank_pin     master->slave  PIN (AUTHENTICATE)
//     bank_dest    master->slave  transfer destination (TRANSACTION)
//     bank_amount  master->slave  amount
//     bank_ack     slave->master  completion strobe
//     bank_ok      slave->master  success flag, valid with ack
//     bank_balance slave->master  post-operation balance, valid with ack
// ---------------------------------------------------------------------------
interface atm_session_ctrl_if #(
  parameter int ACC_W = 12,
  parameter int PIN_W = 4,
  parameter int AMT_W = 11
);
  logic             bank_req;
  logic [2:0]       bank_op;
  logic [ACC_W-1:0] bank_acc;
  logic [PIN_W-1:0] bank_pin;
  logic [ACC_W-1:0] bank_dest;
  logic [AMT_W-1:0] bank_amount;
  logic             bank_ack;
  logic             bank_ok;
  logic [AMT_W-1:0] bank_balance;

  modport master (
    output bank_req, bank_op, bank_acc, bank_pin, bank_dest, bank_amount,
    input  bank_ack, bank_ok, bank_balance
  );

  modport slave (
    input  bank_req, bank_op, bank_acc, bank_pin, bank_dest, bank_amount,
    output bank_ack, bank_ok, bank_balance
  );
endinterface

// File: rtl/atm_lock_table.sv
// ---------------------------------------------------------------------------
// atm_lock_table
//   Small CAM of locked account numbers. Entries are written round-robin so
//   that, once full, the oldest lock is overwritten. Lookup is combinational.
//   Ports:
//     clk, rst_n  clock / synchronous active-low clear of all entries
//     wr_en       write wr_acc at the current pointer, then advance it
//     wr_acc      account to lock
//     lookup_acc  account to search for
//     hit         lookup_acc matches a valid entry
// ---------------------------------------------------------------------------
module atm_lock_table #(
  parameter int ACC_W      = 12,
  parameter int LOCK_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [ACC_W-1:0] wr_acc,
  input  logic [ACC_W-1:0] lookup_acc,
  output logic             hit
);

  localparam int PTR_W = (LOCK_DEPTH > 1) ? $clog2(LOCK_DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LOCK_DEPTH - 1);

  logic [ACC_W-1:0]      entry_acc_reg [LOCK_DEPTH];
  logic [LOCK_DEPTH-1:0] entry_valid_reg;
  logic [LOCK_DEPTH-1:0] hit_vec;
  logic [PTR_W-1:0]      wr_ptr_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
    end else if (wr_en) begin
      wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < LOCK_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          entry_valid_reg[gi] <= 1'b0;
          entry_acc_reg[gi]   <= '0;
        end else if (wr_en && (wr_ptr_reg == PTR_W'(gi))) begin
          entry_valid_reg[gi] <= 1'b1;
          entry_acc_reg[gi]   <= wr_acc;
        end
      end

      assign hit_vec[gi] = entry_valid_reg[gi] && (entry_acc_reg[gi] == lookup_acc);
    end
  endgenerate

  assign hit = |hit_vec;

endmodule

// File: rtl/atm_session_ctrl.sv
// ---------------------------------------------------------------------------
// atm_session_ctrl
//   Session sequencer for one ATM terminal: card -> FIND -> PIN -> AUTH ->
//   menu -> bank operation, with PIN lockout, inactivity timeout, bank
//   response timeout and menu request sanity checks.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     card_valid/acc_number         card insertion (honoured in IDLE only)
//     pin_valid/pin                 PIN entry strobe
//     op_valid/menu_option/amount/dest_acc_number  menu request
//     exit_req                      end session, no error reported
//     bank                          master side of the bank req/ack bus
//     menu_active                   session is in MENU
//     op_done/op_error              1-cycle result pulses
//     err_code                      reason, held until the next pulse
//     balance_out                   last balance returned by a good operation
//     card_locked                   1-cycle pulse: inserted card is locked
// ---------------------------------------------------------------------------
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int ACC_W          = 12,
  parameter int PIN_W          = 4,
  parameter int AMT_W          = 11,
  parameter int MAX_PIN_TRIES  = 3,
  parameter int TIMEOUT_CYCLES = 100,
  parameter int ACK_TIMEOUT    = 16,
  parameter int LOCK_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             card_valid,
  input  logic [ACC_W-1:0] acc_number,
  input  logic             pin_valid,
  input  logic [PIN_W-1:0] pin,
  input  logic             op_valid,
  input  logic [2:0]       menu_option,
  input  logic [AMT_W-1:0] amount,
  input  logic [ACC_W-1:0] dest_acc_number,
  input  logic             exit_req,
  atm_session_ctrl_if.master bank,
  output logic             menu_active,
  output logic             op_done,
  output logic             op_error,
  output logic [2:0]       err_code,
  output logic [AMT_W-1:0] balance_out,
  output logic             card_locked
);

  localparam int TRY_W  = $clog2(MAX_PIN_TRIES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int ACKC_W = $clog2(ACK_TIMEOUT + 1);

  // Counters fire when they already hold LAST and one more cycle elapses,
  // so the event lands exactly on the N-th cycle.
  localparam logic [TRY_W-1:0]  TRY_LAST  = TRY_W'(MAX_PIN_TRIES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ACKC_W-1:0] ACK_LAST  = ACKC_W'(ACK_TIMEOUT - 1);

  state_t            state_reg, state_next;
  logic              bank_req_reg, bank_req_next;
  logic [2:0]        bank_op_reg, bank_op_next;
  logic [ACC_W-1:0]  bank_acc_reg, bank_acc_next;
  logic [PIN_W-1:0]  bank_pin_reg, bank_pin_next;
  logic [ACC_W-1:0]  bank_dest_reg, bank_dest_next;
  logic [AMT_W-1:0]  bank_amount_reg, bank_amount_next;
  logic [ACKC_W-1:0] ack_cnt_reg, ack_cnt_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [TRY_W-1:0]  tries_reg, tries_next;
  logic              op_done_reg, op_done_next;
  logic              op_error_reg, op_error_next;
  logic [2:0]        err_code_reg, err_code_next;
  logic [AMT_W-1:0]  balance_reg, balance_next;
  logic              card_locked_reg, card_locked_next;

  logic lock_hit;
  logic lock_wr_en;
  logic menu_bad;

  atm_lock_table #(
    .ACC_W      (ACC_W),
    .LOCK_DEPTH (LOCK_DEPTH)
  ) u_lock_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (lock_wr_en),
    .wr_acc     (bank_acc_reg),
    .lookup_acc (acc_number),
    .hit        (lock_hit)
  );

  // Menu request sanity: rejected before the bank ever sees it.
  always_comb begin
    menu_bad = 1'b0;
    if (!menu_is_bank_op(menu_option)) begin
      menu_bad = 1'b1;
    end else if (menu_needs_amount(menu_option) && (amount == '0)) begin
      menu_bad = 1'b1;
    end else if ((menu_option == OP_TRANSACTION) && (dest_acc_number == bank_acc_reg)) begin
      menu_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      bank_req_reg    <= 1'b0;
      bank_op_reg     <= '0;
      bank_acc_reg    <= '0;
      bank_pin_reg    <= '0;
      bank_dest_reg   <= '0;
      bank_amount_reg <= '0;
      ack_cnt_reg     <= '0;
      idle_cnt_reg    <= '0;
      tries_reg       <= '0;
      op_done_reg     <= 1'b0;
      op_error_reg    <= 1'b0;
      err_code_reg    <= ERR_NONE;
      balance_reg     <= '0;
      card_locked_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bank_req_reg    <= bank_req_next;
      bank_op_reg     <= bank_op_next;
      bank_acc_reg    <= bank_acc_next;
      bank_pin_reg    <= bank_pin_next;
      bank_dest_reg   <= bank_dest_next;
      bank_amount_reg <= bank_amount_next;
      ack_cnt_reg     <= ack_cnt_next;
      idle_cnt_reg    <= idle_cnt_next;
      tries_reg       <= tries_next;
      op_done_reg     <= op_done_next;
      op_error_reg    <= op_error_next;
      err_code_reg    <= err_code_next;
      balance_reg     <= balance_next;
      card_locked_reg <= card_locked_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bank_req_next    = bank_req_reg;
    bank_op_next     = bank_op_reg;
    bank_acc_next    = bank_acc_reg;
    bank_pin_next    = bank_pin_reg;
    bank_dest_next   = bank_dest_reg;
    bank_amount_next = bank_amount_reg;
    ack_cnt_next     = ack_cnt_reg;
    idle_cnt_next    = idle_cnt_reg;
    tries_next       = tries_reg;
    op_done_next     = 1'b0;
    op_error_next    = 1'b0;
    err_code_next    = err_code_reg;
    balance_next     = balance_reg;
    card_locked_next = 1'b0;
    lock_wr_en       = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (card_valid) begin
          bank_acc_next = acc_number;
          if (lock_hit) begin
            op_error_next    = 1'b1;
            err_code_next    = ERR_LOCKED;
            card_locked_next = 1'b1;
          end else begin
            bank_op_next = OP_FIND;
            tries_next   = '0;
            state_next   = ST_FIND;
          end
        end
      end

      // All three bank states share the handshake: raise req one cycle
      // after entry, drop it on the ack edge, or give up after ACK_TIMEOUT.
      // Panel inputs are deliberately not looked at here.
      ST_FIND, ST_AUTH, ST_EXEC: begin
        if (!bank_req_reg) begin
          bank_req_next = 1'b1;
          ack_cnt_next  = '0;
        end else if (bank.bank_ack) begin
          bank_req_next = 1'b0;
          if (state_reg == ST_FIND) begin
            if (bank.bank_ok) begin
              state_next = ST_ENTER_PIN;
            end else begin
              op_error_next = 1'b1;
              err_code_next = ERR_NOT_FOUND;
              state_next    = ST_IDLE;
            end
          end else if (state_reg == ST_AUTH) begin
            if (bank.bank_ok) begin
              tries_next = '0;
              state_next = ST_MENU;
            end else if (tries_reg == TRY_LAST) begin
              tries_next    = '0;
              lock_wr_en    = 1'b1;
              op_error_next = 1'b1;
              err_code_next = ERR_LOCKED;
              state_next    = ST_IDLE;
            end else begin
              tries_next    = tries_reg + 1'b1;
              op_error_next = 1'b1;
              err_code_next = ERR_BAD_PIN;
              state_next    = ST_ENTER_PIN;
            end
          end else begin
            if (bank.bank_ok) begin
              op_done_next  = 1'b1;
              err_code_next = ERR_NONE;
              balance_next  = bank.bank_balance;
            end else begin
              op_error_next = 1'b1;
              err_code_next = ERR_INSUFFICIENT;
            end
            state_next = ST_MENU;
          end
        end else if (ack_cnt_reg == ACK_LAST) begin
          bank_req_next = 1'b0;
          op_error_next = 1'b1;
          err_code_next = ERR_BANK_TIMEOUT;
          state_next    = ST_IDLE;
        end else begin
          ack_cnt_next = ack_cnt_reg + 1'b1;
        end
      end

      ST_ENTER_PIN: begin
        if (exit_req) begin
          state_next = ST_IDLE;
        end else if (pin_valid) begin
          bank_pin_next = pin;
          bank_op_next  = OP_AUTHENTICATE;
          state_next    = ST_AUTH;
        end else if (!op_valid && (idle_cnt_reg == IDLE_LAST)) begin
          op_error_next = 1'b1;
          err_code_next = ERR_SESSION_TIMEOUT;
          state_next    = ST_IDLE;
        end
      end

      ST_MENU: begin
        if (exit_req) begin
          state_next = ST_IDLE;
        end else if (op_valid) begin
          if (menu_bad) begin
            op_error_next = 1'b1;
            err_code_next = ERR_BAD_REQUEST;
          end else begin
            bank_op_next     = menu_option;
            bank_amount_next = amount;
            bank_dest_next   = dest_acc_number;
            state_next       = ST_EXEC;
          end
        end else if (!pin_valid && (idle_cnt_reg == IDLE_LAST)) begin
          op_error_next = 1'b1;
          err_code_next = ERR_SESSION_TIMEOUT;
          state_next    = ST_IDLE;
        end
      end

      default: begin
        bank_req_next = 1'b0;
        state_next    = ST_IDLE;
      end
    endcase

    // Inactivity counter: reload on any state change or panel strobe,
    // count in the two waiting states, hold while the bank is busy.
    if (state_next != state_reg) begin
      idle_cnt_next = '0;
    end else if ((state_reg == ST_ENTER_PIN) || (state_reg == ST_MENU)) begin
      idle_cnt_next = (pin_valid || op_valid) ? '0 : idle_cnt_reg + 1'b1;
    end
  end

  assign bank.bank_req    = bank_req_reg;
  assign bank.bank_op     = bank_op_reg;
  assign bank.bank_acc    = bank_acc_reg;
  assign bank.bank_pin    = bank_pin_reg;
  assign bank.bank_dest   = bank_dest_reg;
  assign bank.bank_amount = bank_amount_reg;

  assign menu_active = (state_reg == ST_MENU);
  assign op_done     = op_done_reg;
  assign op_error    = op_error_reg;
  assign err_code    = err_code_reg;
  assign balance_out = balance_reg;
  assign card_locked = card_locked_reg;

endmodule
